// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit -- program counter with an optional return-address stack (RAS).
//
// Holds the instruction-memory address. Supports sequential increment,
// conditional relative branch, absolute jump, and call/return.
//
// Build option: macro PC_UNIT_RAS_EN
//   defined   : circular LIFO return stack of RAS_DEPTH entries is built.
//   undefined : no stack; CALL acts as JMP, RET acts as INC, flags are tied off.
//
// Parameters
//   ADDR_W     address width
//   STEP       sequential increment
//   RESET_ADDR pc value after reset
//   RAS_DEPTH  stack entries (>=2, power of two); unused without the stack
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   en         in   advance enable (0 = stall, all state held)
//   op         in   000 INC, 001 BR, 010 JMP, 011 CALL, 100 RET, others HOLD
//   cond       in   branch-taken qualifier for BR
//   offset     in   signed branch offset
//   target     in   absolute address for JMP / CALL
//   pc         out  current instruction address (registered)
//   ras_empty  out  stack holds no entries
//   ras_full   out  stack holds RAS_DEPTH entries
//   ras_ovf    out  one-cycle pulse: CALL while full
//   ras_unf    out  one-cycle pulse: RET while empty
// -----------------------------------------------------------------------------
module pc_unit #(
   parameter int ADDR_W     = 8,
   parameter int STEP       = 1,
   parameter int RESET_ADDR = 0,
   parameter int RAS_DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [2:0]        op,
   input  logic              cond,
   input  logic [ADDR_W-1:0] offset,
   input  logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] pc,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf
);

   localparam logic [2:0] OP_INC  = 3'b000;
   localparam logic [2:0] OP_BR   = 3'b001;
   localparam logic [2:0] OP_JMP  = 3'b010;
   localparam logic [2:0] OP_CALL = 3'b011;
   localparam logic [2:0] OP_RET  = 3'b100;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_inc;

   assign pc_inc = pc_q + ADDR_W'(STEP);

`ifdef PC_UNIT_RAS_EN
   localparam int PTR_W = $clog2(RAS_DEPTH);

   // wptr_q points at the next free slot; the top of stack is wptr_q-1.
   // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two,
   // so a push while full silently overwrites the oldest entry.
   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  top_ptr;
   logic [PTR_W:0]    cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              push, pop;
   logic              stk_empty, stk_full;

   assign top_ptr   = wptr_q - PTR_W'(1);
   assign stk_empty = (cnt_q == '0);
   assign stk_full  = (cnt_q == (PTR_W+1)'(RAS_DEPTH));
`endif

   // Next-pc selection; en=0 leaves pc_d at pc_q.
   always_comb begin
      pc_d = pc_q;
`ifdef PC_UNIT_RAS_EN
      push = 1'b0;
      pop  = 1'b0;
`endif
      if (en) begin
         case (op)
            OP_INC:  pc_d = pc_inc;
            // Offset and pc share a width, so modulo addition equals the
            // sign-extended add.
            OP_BR:   pc_d = cond ? (pc_q + offset) : pc_inc;
            OP_JMP:  pc_d = target;
            OP_CALL: begin
               pc_d = target;
`ifdef PC_UNIT_RAS_EN
               push = 1'b1;
`endif
            end
            OP_RET: begin
`ifdef PC_UNIT_RAS_EN
               // Stack read is asynchronous so RET completes in one cycle.
               if (!stk_empty) begin
                  pop  = 1'b1;
                  pc_d = ras_mem[top_ptr];
               end else begin
                  pc_d = pc_inc;
               end
`else
               pc_d = pc_inc;
`endif
            end
            default: pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= ADDR_W'(RESET_ADDR);
      else       pc_q <= pc_d;
   end

   assign pc = pc_q;

`ifdef PC_UNIT_RAS_EN
   always_comb begin
      wptr_d = wptr_q;
      cnt_d  = cnt_q;
      if (push) begin
         wptr_d = wptr_q + PTR_W'(1);
         if (!stk_full) cnt_d = cnt_q + (PTR_W+1)'(1);
      end else if (pop) begin
         wptr_d = top_ptr;
         cnt_d  = cnt_q - (PTR_W+1)'(1);
      end
   end

   assign ovf_d = push & stk_full;
   assign unf_d = en && (op == OP_RET) && stk_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   // Entry contents need no reset; count and pointer define validity.
   always_ff @(posedge clk) begin
      if (push && !reset) ras_mem[wptr_q] <= pc_inc;
   end

   assign ras_empty = stk_empty;
   assign ras_full  = stk_full;
   assign ras_ovf   = ovf_q;
   assign ras_unf   = unf_q;
`else
   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
   assign ras_ovf   = 1'b0;
   assign ras_unf   = 1'b0;
`endif

endmodule
